// File: rtl/inst_mem_loader.sv
// inst_mem_loader: fetch-port instruction memory filled by a byte-serial loader, holding the core in reset until a full image is loaded
module inst_mem_loader #(
  parameter int ADDR_W = 10,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic [31:0]       addr,
  output logic [31:0]       inst,
  input  logic [7:0]        ld_data,
  input  logic              ld_valid,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              cpu_rst_o,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   word_count
);
  typedef enum logic [1:0] {LOAD, DONE, ERR} state_t;
  state_t r_state, w_next;
  logic [1:0] r_idx;
  logic [23:0] r_shift;
  logic [ADDR_W:0] r_wc;
  logic [31:0] r_mem [0:2**ADDR_W-1];
  logic w_acc, w_full, w_wr, w_unused;
  logic [31:0] w_word;
  assign w_unused = &{1'b0, addr[31:ADDR_W+2], addr[1:0]};
  assign ld_ready = (r_state == LOAD) & ~rst;
  assign cpu_rst_o = rst | (r_state != DONE);
  assign load_done = r_state == DONE;
  assign load_err = r_state == ERR;
  assign word_count = r_wc;
  assign inst = ce ? r_mem[addr[ADDR_W+1:2]] : 32'h0;
  assign w_acc = ld_valid & ld_ready;
  // the counter only ever reaches 2^ADDR_W, so its MSB alone flags a full memory
  assign w_full = r_wc[ADDR_W];
  assign w_wr = w_acc & ~w_full & (r_idx == 2'd3);
  assign w_word = BIG_ENDIAN ? {r_shift, ld_data} : {ld_data, r_shift[7:0], r_shift[15:8], r_shift[23:16]};
  always_comb begin
    w_next = r_state;
    if (r_state == LOAD && w_acc)
      w_next = w_full ? ERR : ld_last ? ((r_idx == 2'd3) ? DONE : ERR) : LOAD;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= LOAD;
      r_idx <= 2'd0;
      r_shift <= 24'h0;
      r_wc <= '0;
    end else begin
      r_state <= w_next;
      if (w_acc && !w_full) begin
        r_idx <= r_idx + 2'd1;
        r_shift <= (r_idx == 2'd3) ? 24'h0 : {r_shift[15:0], ld_data};
        if (r_idx == 2'd3 && !(ld_last && 1'b0)) r_wc <= r_wc + 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wc[ADDR_W-1:0]] <= w_word;
  end
endmodule

// File: tb/tb_inst_mem_loader.sv
// tb_inst_mem_loader: directed checks of load, endianness, error, overflow, aliasing and mid-load reset
module tb_inst_mem_loader;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst_a = 1, ce_a = 0, v_a = 0, l_a = 0;
  logic [31:0] addr_a = 0;
  logic [7:0] d_a = 0;
  logic [31:0] inst_be, inst_le;
  logic rdy_be, crst_be, done_be, err_be, rdy_le, crst_le, done_le, err_le;
  logic [10:0] wc_be, wc_le;
  logic rst_b = 1, ce_b = 0, v_b = 0, l_b = 0;
  logic [31:0] addr_b = 0;
  logic [7:0] d_b = 0;
  logic [31:0] inst_sm;
  logic rdy_sm, crst_sm, done_sm, err_sm;
  logic [2:0] wc_sm;
  int n = 0, errs = 0;

  inst_mem_loader #(.ADDR_W(10), .BIG_ENDIAN(1'b1)) u_be (.clk(clk), .rst(rst_a), .ce(ce_a), .addr(addr_a),
    .inst(inst_be), .ld_data(d_a), .ld_valid(v_a), .ld_last(l_a), .ld_ready(rdy_be), .cpu_rst_o(crst_be),
    .load_done(done_be), .load_err(err_be), .word_count(wc_be));
  inst_mem_loader #(.ADDR_W(10), .BIG_ENDIAN(1'b0)) u_le (.clk(clk), .rst(rst_a), .ce(ce_a), .addr(addr_a),
    .inst(inst_le), .ld_data(d_a), .ld_valid(v_a), .ld_last(l_a), .ld_ready(rdy_le), .cpu_rst_o(crst_le),
    .load_done(done_le), .load_err(err_le), .word_count(wc_le));
  inst_mem_loader #(.ADDR_W(2), .BIG_ENDIAN(1'b1)) u_sm (.clk(clk), .rst(rst_b), .ce(ce_b), .addr(addr_b),
    .inst(inst_sm), .ld_data(d_b), .ld_valid(v_b), .ld_last(l_b), .ld_ready(rdy_sm), .cpu_rst_o(crst_sm),
    .load_done(done_sm), .load_err(err_sm), .word_count(wc_sm));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_a(input logic [7:0] d, input logic l, input int gap);
    repeat (gap) @(negedge clk);
    @(negedge clk); d_a = d; v_a = 1; l_a = l;
    @(posedge clk); #1 v_a = 0; l_a = 0;
  endtask

  task automatic send_b(input logic [7:0] d, input logic l);
    @(negedge clk); d_b = d; v_b = 1; l_b = l;
    @(posedge clk); #1 v_b = 0; l_b = 0;
  endtask

  task automatic reset_a();
    @(negedge clk); rst_a = 1;
    @(negedge clk);
    chk("rst_ready", {31'b0, rdy_be}, 0);
    chk("rst_cpu_rst", {31'b0, crst_be}, 1);
    chk("rst_done_err", {30'b0, done_be, err_be}, 0);
    chk("rst_wc", {21'b0, wc_be}, 0);
    rst_a = 0;
  endtask

  task automatic rd_a(input logic [31:0] a, input logic [31:0] exp, input string tag);
    ce_a = 1; addr_a = a; #1;
    chk(tag, inst_be, exp);
  endtask

  initial begin
    logic [7:0] img [8];
    img = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    reset_a();
    for (int i = 0; i < 7; i++) send_a(img[i], 1'b0, 0);
    chk("cpu_rst_before_last", {31'b0, crst_be}, 1);
    send_a(img[7], 1'b1, 0);
    chk("cpu_rst_after_last", {31'b0, crst_be}, 0);
    chk("done_be", {31'b0, done_be}, 1);
    chk("wc_be", {21'b0, wc_be}, 2);
    chk("ready_after_done", {31'b0, rdy_be}, 0);
    rd_a(0, 32'h12345678, "be_addr0");
    rd_a(4, 32'h9ABCDEF0, "be_addr4");
    rd_a(6, 32'h9ABCDEF0, "be_addr6");
    ce_a = 1; addr_a = 0; #1 chk("le_addr0", inst_le, 32'h78563412);
    addr_a = 4; #1 chk("le_addr4", inst_le, 32'hF0DEBC9A);
    chk("done_le", {31'b0, done_le}, 1);
    send_a(8'h55, 1'b1, 0);
    chk("ignored_wc", {21'b0, wc_be}, 2);
    rd_a(0, 32'h12345678, "ignored_mem");
    ce_a = 0; #1 chk("ce0_inst", inst_be, 0);
    reset_a();
    for (int i = 0; i < 8; i++) send_a(img[i], i == 7, $urandom_range(0, 2));
    chk("gap_done", {31'b0, done_be}, 1);
    chk("gap_wc", {21'b0, wc_be}, 2);
    rd_a(0, 32'h12345678, "gap_addr0");
    rd_a(4, 32'h9ABCDEF0, "gap_addr4");
    reset_a();
    for (int i = 0; i < 5; i++) send_a(8'h11 * (i + 1), i == 4, 0);
    chk("partial_err", {31'b0, err_be}, 1);
    chk("partial_cpu_rst", {31'b0, crst_be}, 1);
    chk("partial_wc", {21'b0, wc_be}, 1);
    rd_a(0, 32'h11223344, "partial_mem0");
    rd_a(4, 32'h9ABCDEF0, "partial_mem1");
    reset_a();
    for (int i = 0; i < 6; i++) send_a(8'h01 + i[7:0], 1'b0, 0);
    reset_a();
    send_a(8'hAA, 0, 0); send_a(8'hBB, 0, 0); send_a(8'hCC, 0, 0); send_a(8'hDD, 1, 0);
    rd_a(0, 32'hAABBCCDD, "midrst_mem0");
    chk("midrst_wc", {21'b0, wc_be}, 1);
    chk("midrst_done", {31'b0, done_be}, 1);
    @(negedge clk); rst_b = 0;
    for (int i = 0; i < 16; i++) send_b(8'h01 + i[7:0], 1'b0);
    chk("sm_full_wc", {29'b0, wc_sm}, 4);
    chk("sm_full_ready", {31'b0, rdy_sm}, 1);
    send_b(8'h77, 1'b0);
    chk("sm_ovf_err", {31'b0, err_sm}, 1);
    chk("sm_ovf_wc", {29'b0, wc_sm}, 4);
    @(negedge clk); rst_b = 1; @(negedge clk); rst_b = 0;
    for (int i = 0; i < 16; i++) send_b(8'h01 + i[7:0], i == 15);
    chk("sm_exact_done", {31'b0, done_sm}, 1);
    chk("sm_exact_wc", {29'b0, wc_sm}, 4);
    ce_b = 0; addr_b = 0; #1 chk("sm_ce0", inst_sm, 0);
    ce_b = 1; addr_b = 16; #1 chk("sm_alias16", inst_sm, 32'h01020304);
    addr_b = 12; #1 chk("sm_addr12", inst_sm, 32'h0D0E0F10);
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end
endmodule
